// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the fetch PC, applies branch/jump redirects,
// flushes IF/ID on a taken redirect and holds one redirect across a stall.
// Ports: CLK, RESET_N (sync, active-low); Stall, PCSrc/BranchTarget,
//   Jump/JumpTarget in; PC, PCPlus4, FlushIFID, RedirectPending,
//   TakenCount out.
module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             Stall,
   input  logic             PCSrc,
   input  logic [31:0]      BranchTarget,
   input  logic             Jump,
   input  logic [31:0]      JumpTarget,
   output logic [31:0]      PC,
   output logic [31:0]      PCPlus4,
   output logic             FlushIFID,
   output logic             RedirectPending,
   output logic [CNT_W-1:0] TakenCount
);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t           state_q, state_n;
   logic [31:0]      pc_q, pc_n;
   logic [31:0]      tgt_q, tgt_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [CNT_W-1:0] cnt_inc;

   logic             req;
   logic [31:0]      req_tgt;

   assign req     = Jump | PCSrc;
   // Jump wins over a branch; targets are forced word-aligned.
   assign req_tgt = Jump ? {JumpTarget[31:2], 2'b00}
                         : {BranchTarget[31:2], 2'b00};

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         pc_q    <= {RESET_PC[31:2], 2'b00};
         tgt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         pc_q    <= pc_n;
         tgt_q   <= tgt_n;
         cnt_q   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state_q;
      pc_n    = pc_q;
      tgt_n   = tgt_q;
      cnt_n   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (!Stall) begin
               if (req) begin
                  pc_n  = req_tgt;
                  cnt_n = cnt_inc;
               end else begin
                  pc_n = pc_q + 32'd4;
               end
            end else if (req) begin
               tgt_n   = req_tgt;
               state_n = PENDING;
            end
         end
         PENDING: begin
            // A req seen here belongs to the same held ID instruction,
            // so the first captured target is the one that counts.
            if (!Stall) begin
               pc_n    = tgt_q;
               cnt_n   = cnt_inc;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign PC              = pc_q;
   assign PCPlus4         = pc_q + 32'd4;
   assign RedirectPending = (state_q == PENDING);
   assign TakenCount      = cnt_q;
   assign FlushIFID       = ~Stall & (RedirectPending | req) & RESET_N;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed testbench for fetch_redirect_unit.
// Second instance with CNT_W=2 exercises counter saturation.
module tb_fetch_redirect_unit;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        Stall = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] BranchTarget = '0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = '0;
   logic [31:0] PC, PCPlus4;
   logic        FlushIFID, RedirectPending;
   logic [15:0] TakenCount;
   logic [31:0] pc2, pc2p4;
   logic        flush2, pend2;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .Stall(Stall), .PCSrc(PCSrc),
      .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
      .PC(PC), .PCPlus4(PCPlus4), .FlushIFID(FlushIFID),
      .RedirectPending(RedirectPending), .TakenCount(TakenCount)
   );

   fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
      .CLK(CLK), .RESET_N(RESET_N), .Stall(Stall), .PCSrc(PCSrc),
      .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
      .PC(pc2), .PCPlus4(pc2p4), .FlushIFID(flush2),
      .RedirectPending(pend2), .TakenCount(cnt2)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_in();
      Stall = 0; PCSrc = 0; Jump = 0;
      BranchTarget = '0; JumpTarget = '0;
   endtask

   task automatic do_reset();
      clear_in();
      RESET_N = 0;
      step();
      RESET_N = 1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      clear_in();
      RESET_N = 0;
      PCSrc = 1; BranchTarget = 32'h40;
      #1;
      checks++;
      if (FlushIFID !== 1'b0) begin
         errors++; $display("FAIL rst_flush got=%b exp=0", FlushIFID);
      end
      step();
      PCSrc = 0;
      RESET_N = 1;
      checks++;
      if (PC !== 32'h0 || RedirectPending !== 1'b0 || TakenCount !== 16'd0) begin
         errors++;
         $display("FAIL rst_state pc=%h pend=%b cnt=%0d exp 0/0/0",
                  PC, RedirectPending, TakenCount);
      end
      exp_pc = 32'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (PC !== exp_pc || FlushIFID !== 1'b0 || TakenCount !== 16'd0 ||
             PCPlus4 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL freerun%0d pc=%h fl=%b cnt=%0d p4=%h exp pc=%h",
                     i, PC, FlushIFID, TakenCount, PCPlus4, exp_pc);
         end
         step();
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_branch();
      do_reset();
      step(); step();
      PCSrc = 1; BranchTarget = 32'h40;
      #1;
      checks++;
      if (PC !== 32'h8 || FlushIFID !== 1'b1) begin
         errors++; $display("FAIL br_flush pc=%h fl=%b exp 8/1", PC, FlushIFID);
      end
      step();
      PCSrc = 0;
      #1;
      checks++;
      if (PC !== 32'h40 || FlushIFID !== 1'b0 || TakenCount !== 16'd1) begin
         errors++;
         $display("FAIL br_target pc=%h fl=%b cnt=%0d exp 40/0/1",
                  PC, FlushIFID, TakenCount);
      end
      step();
      checks++;
      if (PC !== 32'h44) begin
         errors++; $display("FAIL br_next pc=%h exp 44", PC);
      end
   endtask

   task automatic test_stall_branch();
      do_reset();
      Stall = 1; PCSrc = 1; BranchTarget = 32'h80;
      #1;
      checks++;
      if (FlushIFID !== 1'b0 || RedirectPending !== 1'b0) begin
         errors++;
         $display("FAIL st_c1 fl=%b pend=%b exp 0/0", FlushIFID, RedirectPending);
      end
      step();
      checks++;
      if (PC !== 32'h0 || RedirectPending !== 1'b1 || FlushIFID !== 1'b0) begin
         errors++;
         $display("FAIL st_c2 pc=%h pend=%b fl=%b exp 0/1/0",
                  PC, RedirectPending, FlushIFID);
      end
      step();
      BranchTarget = 32'h90;
      step();
      checks++;
      if (PC !== 32'h0 || RedirectPending !== 1'b1) begin
         errors++;
         $display("FAIL st_hold pc=%h pend=%b exp 0/1", PC, RedirectPending);
      end
      Stall = 0;
      #1;
      checks++;
      if (FlushIFID !== 1'b1) begin
         errors++; $display("FAIL st_release_flush fl=%b exp 1", FlushIFID);
      end
      step();
      PCSrc = 0;
      #1;
      checks++;
      if (PC !== 32'h80 || RedirectPending !== 1'b0 || TakenCount !== 16'd1) begin
         errors++;
         $display("FAIL st_apply pc=%h pend=%b cnt=%0d exp 80/0/1",
                  PC, RedirectPending, TakenCount);
      end
      step();
      checks++;
      if (PC !== 32'h84 || TakenCount !== 16'd1) begin
         errors++;
         $display("FAIL st_after pc=%h cnt=%0d exp 84/1", PC, TakenCount);
      end
   endtask

   task automatic test_jump_priority();
      do_reset();
      Jump = 1; JumpTarget = 32'h100;
      PCSrc = 1; BranchTarget = 32'h200;
      #1;
      checks++;
      if (FlushIFID !== 1'b1) begin
         errors++; $display("FAIL jp_flush fl=%b exp 1", FlushIFID);
      end
      step();
      checks++;
      if (PC !== 32'h100 || TakenCount !== 16'd1) begin
         errors++;
         $display("FAIL jp_prio pc=%h cnt=%0d exp 100/1", PC, TakenCount);
      end
      PCSrc = 0; JumpTarget = 32'h103;
      step();
      Jump = 0;
      checks++;
      if (PC !== 32'h100 || TakenCount !== 16'd2) begin
         errors++;
         $display("FAIL jp_align pc=%h cnt=%0d exp 100/2", PC, TakenCount);
      end
      PCSrc = 1; BranchTarget = 32'h2A2;
      step();
      PCSrc = 0;
      checks++;
      if (PC !== 32'h2A0 || TakenCount !== 16'd3) begin
         errors++;
         $display("FAIL br_align pc=%h cnt=%0d exp 2a0/3", PC, TakenCount);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      Jump = 1; JumpTarget = 32'hFFFF_FFFE;
      step();
      Jump = 0;
      checks++;
      if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
         errors++;
         $display("FAIL wrap_top pc=%h p4=%h exp fffffffc/0", PC, PCPlus4);
      end
      step();
      checks++;
      if (PC !== 32'h0) begin
         errors++; $display("FAIL wrap pc=%h exp 0", PC);
      end
   endtask

   task automatic test_reset_pending();
      do_reset();
      Stall = 1; PCSrc = 1; BranchTarget = 32'h80;
      step();
      PCSrc = 0;
      checks++;
      if (RedirectPending !== 1'b1) begin
         errors++; $display("FAIL rp_enter pend=%b exp 1", RedirectPending);
      end
      RESET_N = 0;
      step();
      RESET_N = 1;
      checks++;
      if (PC !== 32'h0 || RedirectPending !== 1'b0 || TakenCount !== 16'd0) begin
         errors++;
         $display("FAIL rp_reset pc=%h pend=%b cnt=%0d exp 0/0/0",
                  PC, RedirectPending, TakenCount);
      end
      Stall = 0;
      #1;
      checks++;
      if (FlushIFID !== 1'b0) begin
         errors++; $display("FAIL rp_noflush fl=%b exp 0", FlushIFID);
      end
      step();
      checks++;
      if (PC !== 32'h4 || TakenCount !== 16'd0) begin
         errors++;
         $display("FAIL rp_after pc=%h cnt=%0d exp 4/0", PC, TakenCount);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp2;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         PCSrc = 1; BranchTarget = 32'(i * 16);
         step();
         exp2 = (i > 3) ? 2'd3 : 2'(i);
         checks++;
         if (cnt2 !== exp2 || TakenCount !== 16'(i) || PC !== 32'(i * 16)) begin
            errors++;
            $display("FAIL sat%0d cnt2=%0d exp=%0d cnt=%0d exp=%0d pc=%h",
                     i, cnt2, exp2, TakenCount, i, PC);
         end
      end
      PCSrc = 0;
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall_branch();
      test_jump_priority();
      test_wrap();
      test_reset_pending();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Consumer end of the branch-decision path: owns the program counter and applies the `PCSrc` decision from the ID-stage branch resolver.
- Also applies the ID-stage jump decision.
- Generates the IF/ID flush for a taken redirect.
- Buffers any redirect that arrives while the front end is stalled by the hazard unit, then applies it on stall release.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_N  input  1  synchronous active-low reset.
- Stall  input  1  hazard-unit freeze of PC and IF/ID.
- PCSrc  input  1  branch taken, from branch resolver (ID stage).
- BranchTarget  input  32  branch target address.
- Jump  input  1  unconditional jump in ID.
- JumpTarget  input  32  jump target address.
- PC  output  32  current fetch address (registered).
- PCPlus4  output  32  PC + 4 (combinational from PC).
- FlushIFID  output  1  zero the IF/ID register this cycle.
- RedirectPending  output  1  a captured redirect is waiting for stall release (registered).
- TakenCount  output  CNT_W  number of redirects applied, saturating.

Behaviour:
- Reset (RESET_N=0 at rising edge):
  - PC <= RESET_PC; pending valid <= 0; pending target <= 0; TakenCount <= 0.
  - Reset has priority over all other inputs.
  - FlushIFID is forced 0 while RESET_N=0.
- Request selection: req = Jump | PCSrc. If both are high, Jump wins; req_target = JumpTarget.
- Alignment: every target loaded into PC has bits [1:0] forced to 2'b00. PC always stays word-aligned.
- State, IDLE (pending=0):
  - Stall=0, req=1: PC <= req_target; FlushIFID=1 in that same cycle; TakenCount increments.
  - Stall=0, req=0: PC <= PC+4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000); FlushIFID=0.
  - Stall=1, req=1: PC holds; capture req_target into pending; go to PENDING next cycle; FlushIFID=0.
  - Stall=1, req=0: PC holds; no change.
- State, PENDING (RedirectPending=1):
  - Stall=1: PC holds. New req is ignored, because it is the same held ID instruction; the first captured target is kept.
  - Stall=0: PC <= pending target; FlushIFID=1; TakenCount increments; clear pending; return to IDLE. A simultaneous req in this cycle is ignored.
- FlushIFID is combinational: ~Stall & (pending | req) & RESET_N.
- Latency: an unstalled redirect takes effect at the next edge (1 cycle); the wrong-path instruction already fetched is flushed in the same cycle.
- TakenCount saturates at all-ones and does not wrap.
- Reset asserted while PENDING discards the pending target. After reset, PC=RESET_PC and no flush occurs.

Test Plan:
- Reset then free-run, RESET_PC=0, Stall=0, no req, 4 cycles -> PC = 0, 4, 8, C; FlushIFID=0; TakenCount=0.
- Unstalled branch: at PC=8, PCSrc=1, BranchTarget=32'h40 for 1 cycle -> FlushIFID=1 that cycle; next PC=0x40, then 0x44; TakenCount=1.
- Branch during stall: Stall=1 with PCSrc=1, target 0x80 for 3 cycles, then target changes to 0x90 -> PC frozen; RedirectPending=1 from the 2nd cycle. On Stall=0: FlushIFID=1, PC=0x80 (not 0x90), RedirectPending=0.
- Simultaneous Jump=1 (0x100) and PCSrc=1 (0x200), plus misaligned jump 0x103 -> PC=0x100 in both cases; TakenCount increments once per event.
- Reset mid-pending: enter PENDING with target 0x80, assert RESET_N=0 for 1 cycle while Stall=1 -> PC=RESET_PC, RedirectPending=0; after Stall=0, PC=RESET_PC+4 and no flush.
- Saturation with CNT_W=2: apply 5 unstalled redirects -> TakenCount = 1, 2, 3, 3, 3.
